// File: rtl/exec_occupancy_tracker_pkg.sv
// Shared types and defaults for the execute-occupancy tracker.
//   exec_state_t   : occupancy state of the single execute unit
//   EXEC_*_LAT     : default short/long latencies in cycles
//   EXEC_CNT_W     : default retirement counter width
//   exec_rem_w()   : width of the remaining-cycle counter for a given long latency
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXEC_SHORT = 2'd1,
        EXEC_LONG  = 2'd2
    } exec_state_t;

    localparam int EXEC_SHORT_LAT = 1;
    localparam int EXEC_LONG_LAT  = 4;
    localparam int EXEC_CNT_W     = 16;

    // The counter must be able to hold LONG_LAT itself, hence the +1.
    function automatic int exec_rem_w(input int long_lat);
        return $clog2(long_lat + 1);
    endfunction

endpackage

// File: rtl/exec_occupancy_tracker_if.sv
// Issue/occupancy/retire bundle between the level-2 instruction buffer and
// the execute-occupancy tracker.
//   master (buffer side)  : drives issue_valid, issue_is_long, flush;
//                           observes lookahead, retire and error outputs.
//   slave  (tracker side) : the mirror image.
interface exec_occupancy_tracker_if #(
    parameter int CNT_W = exec_pkg::EXEC_CNT_W
) ();

    logic             issue_valid;
    logic             issue_is_long;
    logic             flush;
    logic             exec_busy;
    logic             exec_will_free_next;
    logic             retire_valid;
    logic             retire_was_long;
    logic [CNT_W-1:0] retired_count;
    logic             err_issue_busy;

    modport master (
        output issue_valid,
        output issue_is_long,
        output flush,
        input  exec_busy,
        input  exec_will_free_next,
        input  retire_valid,
        input  retire_was_long,
        input  retired_count,
        input  err_issue_busy
    );

    modport slave (
        input  issue_valid,
        input  issue_is_long,
        input  flush,
        output exec_busy,
        output exec_will_free_next,
        output retire_valid,
        output retire_was_long,
        output retired_count,
        output err_issue_busy
    );

endinterface

// File: rtl/exec_occupancy_tracker_counter.sv
// Remaining-cycle down counter for the in-flight execute instruction.
//   clk        : rising-edge clock
//   clear      : force rem to 0 (highest priority; also used for reset)
//   load       : load rem with load_value
//   load_value : latency of the newly accepted instruction
//   decrement  : rem <= rem - 1 (lowest priority)
//   rem        : remaining cycles of the in-flight instruction (0 = none)
//   is_one     : rem == 1, i.e. the instruction completes at the next edge
//   is_zero    : rem == 0, i.e. nothing in flight
module latency_down_counter #(
    parameter int REM_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [REM_W-1:0] load_value,
    input  logic             decrement,
    output logic [REM_W-1:0] rem,
    output logic             is_one,
    output logic             is_zero
);

    always_ff @(posedge clk) begin
        if (clear) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_value;
        end else if (decrement) begin
            rem <= rem - REM_W'(1);
        end
    end

    assign is_one  = (rem == REM_W'(1));
    assign is_zero = (rem == '0);

endmodule

// File: rtl/exec_occupancy_tracker.sv
// Occupancy model of the single execute unit downstream of the level-2
// instruction buffer. Accepts one instruction per cycle when the unit is
// free or freeing, holds it for SHORT_LAT or LONG_LAT cycles, and reports
// retirements and issue-while-busy protocol errors.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of exec_occupancy_tracker_if
//           in : issue_valid, issue_is_long, flush
//           out: exec_busy, exec_will_free_next (lookahead, from state only),
//                retire_valid/retire_was_long (one-cycle pulse after completion),
//                retired_count (wraps), err_issue_busy (sticky until reset)
module exec_occupancy_tracker
    import exec_pkg::*;
#(
    parameter int SHORT_LAT = EXEC_SHORT_LAT,
    parameter int LONG_LAT  = EXEC_LONG_LAT,
    parameter int CNT_W     = EXEC_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    exec_occupancy_tracker_if.slave   bus
);

    localparam int REM_W = exec_rem_w(LONG_LAT);

    exec_state_t      state_q;
    logic [REM_W-1:0] rem_q;
    logic             rem_is_one;
    logic             rem_is_zero;

    logic             busy;
    logic             will_free;
    logic             accept;
    logic             issue_blocked;

    logic             ctr_clear;
    logic             ctr_dec;
    logic [REM_W-1:0] ctr_load_value;

    logic             retire_vld_p1;
    logic             retire_long_p1;
    logic [CNT_W-1:0] retired_cnt_p1;
    logic             err_busy_q;

    // Lookahead is a pure function of registered state so the buffer can use
    // it in the same cycle it chooses between pop and bypass.
    assign busy      = (state_q != IDLE);
    assign will_free = rem_is_one;

    assign accept = bus.issue_valid && (!busy || will_free) && !bus.flush;

    // rem is non-zero exactly while an instruction is in flight, so "busy and
    // not freeing" is the same as rem > 1.
    assign issue_blocked = bus.issue_valid && !rem_is_zero && !rem_is_one;

    assign ctr_load_value = bus.issue_is_long ? REM_W'(LONG_LAT) : REM_W'(SHORT_LAT);

    // Completion without a replacement returns rem to 0 via clear; a new
    // accept in the freeing cycle overrides it with a fresh load.
    assign ctr_clear = !reset || bus.flush || (rem_is_one && !accept);
    assign ctr_dec   = (rem_q > REM_W'(1)) && !accept;

    latency_down_counter #(
        .REM_W (REM_W)
    ) u_rem (
        .clk        (clk),
        .clear      (ctr_clear),
        .load       (accept),
        .load_value (ctr_load_value),
        .decrement  (ctr_dec),
        .rem        (rem_q),
        .is_one     (rem_is_one),
        .is_zero    (rem_is_zero)
    );

    // ---- stage p1: occupancy state, retire pulse, counter, error flag ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            retire_vld_p1  <= 1'b0;
            retire_long_p1 <= 1'b0;
            retired_cnt_p1 <= '0;
            err_busy_q     <= 1'b0;
        end else if (bus.flush) begin
            state_q       <= IDLE;
            retire_vld_p1 <= 1'b0;
        end else begin
            retire_vld_p1 <= rem_is_one;
            if (rem_is_one) begin
                retire_long_p1 <= (state_q == EXEC_LONG);
                retired_cnt_p1 <= retired_cnt_p1 + CNT_W'(1);
            end

            if (accept) begin
                state_q <= bus.issue_is_long ? EXEC_LONG : EXEC_SHORT;
            end else if (rem_is_one) begin
                state_q <= IDLE;
            end

            if (issue_blocked) begin
                err_busy_q <= 1'b1;
            end
        end
    end

    assign bus.exec_busy           = busy;
    assign bus.exec_will_free_next = will_free;
    assign bus.retire_valid        = retire_vld_p1;
    assign bus.retire_was_long     = retire_long_p1;
    assign bus.retired_count       = retired_cnt_p1;
    assign bus.err_issue_busy      = err_busy_q;

endmodule
